// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x-oversampled UART receiver (8N1) with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY_ODD parameter and the parity_err output.
module uart_rx_deserializer #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
   ,parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 srx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 break_det
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   state_t                 state_q, state_d;
   logic [1:0]             sync_q;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   break_q, break_d;
   logic                   srx_s, stop_smp, good, load;
`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_d;
   logic                   parity_err_q, parity_err_d;
`endif

   assign srx_s = sync_q[1];

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
`endif
      if (baud_tick) begin
         case (state_q)
            IDLE: if (!srx_s) begin
               state_d = START;
               tick_d  = '0;
            end
            START: if (tick_q == T_MID) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = srx_s ? IDLE : DATA;
            end else tick_d = tick_q + 1'b1;
            DATA: if (tick_q == T_END) begin
               tick_d  = '0;
               shreg_d = {srx_s, shreg_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               state_d = (bit_q == B_LAST) ? AFTER_DATA : DATA;
            end else tick_d = tick_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick_q == T_END) begin
               tick_d  = '0;
               par_d   = srx_s;
               state_d = STOP;
            end else tick_d = tick_q + 1'b1;
`endif
            STOP: if (tick_q == T_END) begin
               tick_d   = '0;
               stop_smp = 1'b1;
               state_d  = srx_s ? IDLE : WAIT_IDLE;
            end else tick_d = tick_q + 1'b1;
            WAIT_IDLE: state_d = srx_s ? IDLE : WAIT_IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A good byte loads if the holding register is free or is being drained this same cycle.
   always_comb begin
      good        = stop_smp & srx_s;
      load        = good & (~rx_valid_q | rx_ready);
      rx_data_d   = load ? shreg_q : rx_data_q;
      rx_valid_d  = load | (rx_valid_q & ~rx_ready);
      frame_err_d = stop_smp & ~srx_s;
      break_d     = frame_err_d & (shreg_q == '0);
      overrun_d   = good & rx_valid_q & ~rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err_d = stop_smp & ((^{shreg_q, par_q}) != PARITY_ODD);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         state_q     <= IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         break_q     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], srx};
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         break_q     <= break_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign break_det = break_q;
endmodule
